baud_rate_gen: RTL and testbench

BAUD_RATE_GEN -- requirements
Module: baud_rate_gen

---
 rtl/baud_pkg.sv | 9 +
 rtl/baud_rate_gen_mod_counter.sv | 35 +++
 rtl/baud_rate_gen.sv | 83 ++++++++
 tb/tb_baud_rate_gen.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/baud_pkg.sv
// Shared baud-rate constants for the UART generator, transmitter and receiver.
package baud_pkg;

    localparam int MIN_DIV          = 2;
    localparam int BAUD_CNT_W       = 16;
    localparam int BAUD_OVERSAMPLE  = 16;
    localparam int BAUD_DEFAULT_DIV = 27;

endpackage

// File: rtl/baud_rate_gen_mod_counter.sv
// Modulo-N counter with runtime modulus, synchronous clear and a wrap strobe.
module mod_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] modulus,
    output logic [W-1:0] count_nxt,
    output logic         wrap
);

    logic [W-1:0] count;

    assign wrap = en && (count == modulus - W'(1));

    always_comb begin
        count_nxt = count;
        if (clr || wrap) begin
            count_nxt = '0;
        end else if (en) begin
            count_nxt = count + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/baud_rate_gen.sv
// Programmable baud-rate generator: oversample strobe, bit strobe and a 50% bit clock,
// with divisor changes deferred to a tick boundary so the bit phase is kept.
module baud_rate_gen
    import baud_pkg::*;
#(
    parameter int CNT_W       = BAUD_CNT_W,
    parameter int OVERSAMPLE  = BAUD_OVERSAMPLE,
    parameter int DEFAULT_DIV = BAUD_DEFAULT_DIV
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_i,
    input  logic             div_load,
    output logic             div_ack,
    output logic             div_err,
    output logic             os_tick,
    output logic             bit_tick,
    output logic             clk_out
);

    localparam int             OS_W    = $clog2(OVERSAMPLE + 1);
    localparam logic [OS_W-1:0] OS_MOD  = OS_W'(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2);

    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] pend_div;
    logic             pend;
    logic             req_ok;
    logic             apply;
    logic [CNT_W-1:0] cnt_nxt_unused;
    logic [OS_W-1:0]  os_cnt_nxt;

    assign req_ok = (div_i >= CNT_W'(MIN_DIV));
    // A pending divisor only lands on a tick or while stopped, never mid-period.
    assign apply  = pend && (os_tick || !en);

    mod_counter #(.W(CNT_W)) u_prescale (
        .clk       (clk_in),
        .rst_n     (rst),
        .en        (en),
        .clr       (apply),
        .modulus   (div_q),
        .count_nxt (cnt_nxt_unused),
        .wrap      (os_tick)
    );

    mod_counter #(.W(OS_W)) u_os_cnt (
        .clk       (clk_in),
        .rst_n     (rst),
        .en        (os_tick),
        .clr       (1'b0),
        .modulus   (OS_MOD),
        .count_nxt (os_cnt_nxt),
        .wrap      (bit_tick)
    );

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            div_q    <= CNT_W'(DEFAULT_DIV);
            pend_div <= CNT_W'(DEFAULT_DIV);
            pend     <= 1'b0;
            div_ack  <= 1'b0;
            div_err  <= 1'b0;
            clk_out  <= 1'b0;
        end else begin
            div_ack <= apply;
            div_err <= div_load && !req_ok;
            clk_out <= (os_cnt_nxt >= OS_HALF);
            if (apply) begin
                div_q <= pend_div;
            end
            // A request arriving in the apply cycle stays queued behind the one applied.
            if (div_load && req_ok) begin
                pend_div <= div_i;
                pend     <= 1'b1;
            end else if (apply) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_baud_rate_gen.sv
// Randomised and directed bench for baud_rate_gen against a countdown/tick-count model.
module tb_baud_rate_gen;

    localparam int CW  = 16;
    localparam int OS  = 16;
    localparam int DEF = 4;

    logic          clk_in   = 1'b0;
    logic          rst      = 1'b0;
    logic          en       = 1'b0;
    logic [CW-1:0] div_i    = '0;
    logic          div_load = 1'b0;
    logic          div_ack, div_err, os_tick, bit_tick, clk_out;

    int errors = 0;
    int checks = 0;

    // Model: cycles left until the next tick, ticks seen within the current bit.
    int m_div, m_left, m_os, m_pend_div;
    bit m_pend, m_clk, m_ack, m_err;

    baud_rate_gen #(.CNT_W(CW), .OVERSAMPLE(OS), .DEFAULT_DIV(DEF)) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .en       (en),
        .div_i    (div_i),
        .div_load (div_load),
        .div_ack  (div_ack),
        .div_err  (div_err),
        .os_tick  (os_tick),
        .bit_tick (bit_tick),
        .clk_out  (clk_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [4:0] dut_vec();
        return {os_tick, bit_tick, clk_out, div_ack, div_err};
    endfunction

    function automatic logic [4:0] exp_vec();
        logic t;
        t = en && (m_left == 1);
        return {t, t && (m_os == OS - 1), m_clk, m_ack, m_err};
    endfunction

    task automatic model_reset();
        m_div = DEF; m_left = DEF; m_os = 0; m_pend_div = DEF;
        m_pend = 0; m_clk = 0; m_ack = 0; m_err = 0;
    endtask

    task automatic model_update();
        bit t, apply;
        t     = en && (m_left == 1);
        apply = m_pend && (t || !en);
        m_ack = apply;
        m_err = div_load && (div_i < 2);
        if (t) m_os = (m_os + 1) % OS;
        if (apply) begin
            m_div  = m_pend_div;
            m_left = m_div;
        end else if (t) begin
            m_left = m_div;
        end else if (en) begin
            m_left = m_left - 1;
        end
        if (div_load && div_i >= 2) begin
            m_pend_div = int'(div_i);
            m_pend     = 1;
        end else if (apply) begin
            m_pend = 0;
        end
        m_clk = (m_os >= OS / 2);
    endtask

    task automatic tick_clk();
        @(posedge clk_in);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        rst = 0; en = 0; div_load = 0; div_i = '0;
        model_reset();
        repeat (2) @(posedge clk_in);
        #1 rst = 1;
    endtask

    task automatic test_reset();
        rst = 0; en = 1; div_load = 1; div_i = 16'd1;
        model_reset();
        @(negedge clk_in);
        checks++;
        if (dut_vec() !== 5'b0) begin
            errors++; $display("FAIL reset_outputs got=%b exp=00000", dut_vec());
        end
        @(posedge clk_in);
        #1 rst = 1; div_load = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_in);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL reset_release c=%0d got=%b exp=%b", c, dut_vec(), exp_vec());
            end
            tick_clk();
        end
    endtask

    task automatic test_default_timing();
        int first_os = -1, first_bit = -1, first_high = -1, n_os = 0;
        bit clk64 = 1'b1;
        do_reset();
        for (int c = 0; c < 70; c++) begin
            en = 1;
            @(negedge clk_in);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL default_model c=%0d got=%b exp=%b", c, dut_vec(), exp_vec());
            end
            if (os_tick && first_os < 0) first_os = c;
            if (os_tick && c <= 63) n_os++;
            if (bit_tick && first_bit < 0) first_bit = c;
            if (clk_out && first_high < 0) first_high = c;
            if (c == 64) clk64 = clk_out;
            tick_clk();
        end
        checks++; if (first_os !== 3) begin errors++; $display("FAIL default_first_os got=%0d exp=3", first_os); end
        checks++; if (n_os !== 16) begin errors++; $display("FAIL default_os_count got=%0d exp=16", n_os); end
        checks++; if (first_bit !== 63) begin errors++; $display("FAIL default_first_bit got=%0d exp=63", first_bit); end
        checks++; if (first_high !== 32) begin errors++; $display("FAIL default_clk_rise got=%0d exp=32", first_high); end
        checks++; if (clk64 !== 1'b0) begin errors++; $display("FAIL default_clk_fall got=%0b exp=0", clk64); end
    endtask

    task automatic test_enable_gap();
        int gap_ticks = 0, next_os = -1, clk_changes = 0;
        logic clk_ref = 1'b0;
        do_reset();
        for (int c = 0; c < 30; c++) begin
            en = !(c >= 5 && c < 15);
            @(negedge clk_in);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL gap_model c=%0d got=%b exp=%b", c, dut_vec(), exp_vec());
            end
            if (c == 5) clk_ref = clk_out;
            if (c >= 5 && c < 15) begin
                if (os_tick || bit_tick) gap_ticks++;
                if (clk_out !== clk_ref) clk_changes++;
            end
            if (c >= 15 && os_tick && next_os < 0) next_os = c;
            tick_clk();
        end
        checks++; if (gap_ticks !== 0) begin errors++; $display("FAIL gap_ticks got=%0d exp=0", gap_ticks); end
        checks++; if (next_os !== 17) begin errors++; $display("FAIL gap_next_os got=%0d exp=17", next_os); end
        checks++; if (clk_changes !== 0) begin errors++; $display("FAIL gap_clk_hold got=%0d exp=0", clk_changes); end
    endtask

    task automatic test_div_change();
        int os_cyc[$];
        int first_ack = -1, n_ack = 0, first_bit = -1;
        do_reset();
        for (int c = 0; c < 100; c++) begin
            en = 1; div_load = (c == 1); div_i = 16'd6;
            @(negedge clk_in);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL divchg_model c=%0d got=%b exp=%b", c, dut_vec(), exp_vec());
            end
            if (os_tick) os_cyc.push_back(c);
            if (div_ack) begin n_ack++; if (first_ack < 0) first_ack = c; end
            if (bit_tick && first_bit < 0) first_bit = c;
            tick_clk();
        end
        div_load = 0;
        checks++; if (first_ack !== 4 || n_ack !== 1) begin
            errors++; $display("FAIL divchg_ack got=%0d/%0d exp=4/1", first_ack, n_ack); end
        checks++; if (os_cyc.size() < 3 || os_cyc[1] !== 9 || os_cyc[2] !== 15) begin
            errors++; $display("FAIL divchg_ticks got=%p exp=3,9,15...", os_cyc); end
        checks++; if (first_bit !== 93) begin errors++; $display("FAIL divchg_bit got=%0d exp=93", first_bit); end
    endtask

    task automatic test_div_err();
        int n_err = 0, n_ack = 0, n_os = 0, first_err = -1;
        do_reset();
        for (int c = 0; c < 30; c++) begin
            en = 1;
            div_load = (c == 2 || c == 5);
            div_i = (c == 2) ? 16'd1 : 16'd0;
            @(negedge clk_in);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL err_model c=%0d got=%b exp=%b", c, dut_vec(), exp_vec());
            end
            if (div_err) begin n_err++; if (first_err < 0) first_err = c; end
            if (div_ack) n_ack++;
            if (os_tick) n_os++;
            tick_clk();
        end
        div_load = 0;
        checks++; if (first_err !== 3 || n_err !== 2) begin
            errors++; $display("FAIL err_pulse got=%0d/%0d exp=3/2", first_err, n_err); end
        checks++; if (n_ack !== 0) begin errors++; $display("FAIL err_no_ack got=%0d exp=0", n_ack); end
        checks++; if (n_os !== 7) begin errors++; $display("FAIL err_div_kept got=%0d exp=7", n_os); end
    endtask

    task automatic test_back_to_back();
        int os_cyc[$];
        int ack_early = 0, ack_cyc[$];
        do_reset();
        for (int c = 0; c < 30; c++) begin
            en = 1;
            div_load = (c == 0 || c == 1 || c == 3);
            div_i = (c == 0) ? 16'd8 : (c == 1) ? 16'd5 : 16'd7;
            @(negedge clk_in);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL b2b_model c=%0d got=%b exp=%b", c, dut_vec(), exp_vec());
            end
            if (os_tick) os_cyc.push_back(c);
            if (div_ack) begin ack_cyc.push_back(c); if (c < 8) ack_early++; end
            tick_clk();
        end
        div_load = 0;
        checks++; if (ack_early !== 1) begin errors++; $display("FAIL b2b_single_ack got=%0d exp=1", ack_early); end
        checks++; if (ack_cyc.size() !== 2 || ack_cyc[0] !== 4 || ack_cyc[1] !== 9) begin
            errors++; $display("FAIL b2b_ack_cycles got=%p exp=4,9", ack_cyc); end
        checks++; if (os_cyc.size() < 3 || os_cyc[0] !== 3 || os_cyc[1] !== 8 || os_cyc[2] !== 15) begin
            errors++; $display("FAIL b2b_ticks got=%p exp=3,8,15...", os_cyc); end
    endtask

    task automatic test_async_reset();
        int first_os = -1, n_ack = 0;
        logic clk_before = 1'b0;
        do_reset();
        for (int c = 0; c <= 42; c++) begin
            en = 1; div_load = (c == 40); div_i = 16'd9;
            @(negedge clk_in);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL areset_model c=%0d got=%b exp=%b", c, dut_vec(), exp_vec());
            end
            if (c == 42) clk_before = clk_out;
            else tick_clk();
        end
        checks++; if (clk_before !== 1'b1) begin errors++; $display("FAIL areset_pre_clk got=%0b exp=1", clk_before); end
        #2 rst = 0;
        #1;
        checks++;
        if (dut_vec() !== 5'b0) begin
            errors++; $display("FAIL areset_immediate got=%b exp=00000", dut_vec());
        end
        model_reset();
        repeat (2) @(posedge clk_in);
        #1 rst = 1;
        for (int c = 0; c < 70; c++) begin
            en = 1;
            @(negedge clk_in);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL areset_resume c=%0d got=%b exp=%b", c, dut_vec(), exp_vec());
            end
            if (os_tick && first_os < 0) first_os = c;
            if (div_ack) n_ack++;
            tick_clk();
        end
        checks++; if (first_os !== 3) begin errors++; $display("FAIL areset_first_os got=%0d exp=3", first_os); end
        checks++; if (n_ack !== 0) begin errors++; $display("FAIL areset_no_ack got=%0d exp=0", n_ack); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            en       = ($urandom_range(0, 9) != 0);
            div_load = ($urandom_range(0, 7) == 0);
            div_i    = CW'($urandom_range(0, 9));
            @(negedge clk_in);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL random c=%0d got=%b exp=%b", c, dut_vec(), exp_vec());
            end
            tick_clk();
        end
        div_load = 0;
    endtask

    initial begin
        test_reset();
        test_default_timing();
        test_enable_gap();
        test_div_change();
        test_div_err();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
